// File: rtl/div_sched_pkg.sv
// ============================================================================
// Module  : div_sched_pkg
// Brief   : Shared types and helpers for the divider scheduler.
//           This package holds the FSM state encoding, the default datapath
//           width, and the round-robin pick function.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_sched_pkg;

   // Width of the shared divider core's operands and results
   localparam int DIV_DATA_W = 16;

   // Largest requester count the pick function handles
   localparam int RR_MAX_REQ = 8;

   // Scheduler FSM encoding; explicit two-bit width
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Return the first set bit of valid at or after ptr, wrapping modulo nreq.
   // If no bit is set the result is ptr; the caller qualifies it with |valid.
   function automatic logic [2:0] rr_pick(input logic [7:0]  valid,
                                          input logic [2:0]  ptr,
                                          input int unsigned nreq);
      logic [2:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         // ptr < nreq and i < nreq, so one subtraction is enough to wrap
         idx = 32'(ptr) + i;
         if (idx >= nreq) begin
            idx = idx - nreq;
         end
         if ((i < nreq) && !found && valid[3'(idx)]) begin
            pick  = 3'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_sched_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Round-robin arbiter with a combinational grant.
//           The arbiter drives a one-hot ready only while enable is high.
//           The search pointer moves one past the winner on each handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import div_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] req_ready,
   output logic [ID_W-1:0] grant_id,
   output logic            handshake
);

   logic [ID_W-1:0] r_ptr;
   logic [2:0]      w_pick;
   logic            w_any;

   assign w_any     = |req_valid;
   assign w_pick    = rr_pick(8'(req_valid), 3'(r_ptr), 32'(NREQ));
   assign grant_id  = ID_W'(w_pick);

   // The picked index is always a valid requester whenever any bit is set,
   // so the handshake needs only enable and a non-empty request vector
   assign handshake = enable & w_any;
   assign req_ready = handshake ? (NREQ'(1) << w_pick) : '0;

   // Advance the pointer past the winner so that it has lowest priority next
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (handshake) begin
         r_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/div_sched.sv
// ============================================================================
// Module  : div_sched
// Brief   : Shares a single signed sequential divider among NREQ requesters.
//           Requests are granted round-robin and the operands are latched.
//           The core is started with a one-cycle pulse. The scheduler waits
//           for the core's done pulse, then holds an ID-tagged response
//           until the consumer accepts it.
//           Optional build macro: DIV_ZERO_CHECK_EN. When it is defined, a
//           zero divisor is answered locally with rsp_dz=1 and the core is
//           never started.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sched
   import div_sched_pkg::*;
#(
   parameter  int NREQ   = 4,
   parameter  int DATA_W = DIV_DATA_W,
   localparam int ID_W   = $clog2(NREQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*DATA_W-1:0]   req_dividend,
   input  logic [NREQ*DATA_W-1:0]   req_divisor,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [DATA_W-1:0]        rsp_quotient,
   output logic [DATA_W-1:0]        rsp_remainder,
   output logic                     rsp_dz,
   output logic                     div_start,
   output logic [DATA_W-1:0]        div_dividend,
   output logic [DATA_W-1:0]        div_divisor,
   input  logic                     div_done,
   input  logic [DATA_W-1:0]        div_quotient,
   input  logic [DATA_W-1:0]        div_remainder,
   output logic                     busy
);

   state_t              r_state;
   state_t              w_state_next;

   logic                w_idle;
   logic                w_hs;
   logic [ID_W-1:0]     w_grant_id;
   logic [DATA_W-1:0]   w_sel_dividend;
   logic [DATA_W-1:0]   w_sel_divisor;
   logic                w_dz_hit;

   logic [ID_W-1:0]     r_id;
   logic [DATA_W-1:0]   r_dividend;
   logic [DATA_W-1:0]   r_divisor;
   logic [DATA_W-1:0]   r_quotient;
   logic [DATA_W-1:0]   r_remainder;
   logic                r_dz;

   assign w_idle = (r_state == IDLE);

   // Grants are offered only in IDLE, so at most one request is ever in flight
   rr_arbiter #(
      .NREQ      (NREQ),
      .ID_W      (ID_W)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .enable    (w_idle),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .grant_id  (w_grant_id),
      .handshake (w_hs)
   );

   // Operands of the requester that wins the current grant
   assign w_sel_dividend = req_dividend[w_grant_id*DATA_W +: DATA_W];
   assign w_sel_divisor  = req_divisor [w_grant_id*DATA_W +: DATA_W];

`ifdef DIV_ZERO_CHECK_EN
   // A zero divisor is answered locally, so the core never sees it
   assign w_dz_hit = (w_sel_divisor == '0);
`else
   // Zero divisors go to the core like any other operand
   assign w_dz_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and the state-decoded control outputs
   always_comb begin
      w_state_next = r_state;
      div_start    = 1'b0;
      rsp_valid    = 1'b0;
      busy         = 1'b1;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (w_hs) begin
               w_state_next = w_dz_hit ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            div_start    = 1'b1;
            w_state_next = WAIT;
         end
         WAIT: begin
            if (div_done) begin
               w_state_next = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            // Leaving straight to IDLE leaves one bubble before the next grant
            if (rsp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Capture operands on a grant and results on core completion.
   // Results are held steady while the response is stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_id        <= '0;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dz        <= 1'b0;
      end else begin
         if (w_idle && w_hs) begin
            r_id       <= w_grant_id;
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
            r_dz       <= w_dz_hit;
            if (w_dz_hit) begin
               // The local answer for a zero divisor is -1 with the dividend as remainder
               r_quotient  <= '1;
               r_remainder <= w_sel_dividend;
            end
         end
         // A done pulse outside WAIT belongs to no request and is dropped
         if ((r_state == WAIT) && div_done) begin
            r_quotient  <= div_quotient;
            r_remainder <= div_remainder;
         end
      end
   end

   assign div_dividend  = r_dividend;
   assign div_divisor   = r_divisor;
   assign rsp_id        = r_id;
   assign rsp_quotient  = r_quotient;
   assign rsp_remainder = r_remainder;
   assign rsp_dz        = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_div_sched.sv
// ============================================================================
// Module  : tb_div_sched
// Brief   : Self-checking bench for div_sched. A behavioural core with a fixed
//           17-cycle latency supplies results. A scoreboard queue holds the
//           expected responses, which are compared as the DUT returns them.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_sched;
   import div_sched_pkg::*;

   localparam int NREQ   = 4;
   localparam int DATA_W = 16;
   localparam int ID_W   = 2;
   localparam int LAT    = 17;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] q;
      logic [DATA_W-1:0] r;
      logic              dz;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*DATA_W-1:0] req_dividend;
   logic [NREQ*DATA_W-1:0] req_divisor;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [DATA_W-1:0]      rsp_quotient;
   logic [DATA_W-1:0]      rsp_remainder;
   logic                   rsp_dz;
   logic                   div_start;
   logic [DATA_W-1:0]      div_dividend;
   logic [DATA_W-1:0]      div_divisor;
   logic                   div_done;
   logic [DATA_W-1:0]      div_quotient;
   logic [DATA_W-1:0]      div_remainder;
   logic                   busy;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   int   grant_log[$];
   logic [NREQ-1:0] hs_mask = '0;
   int   start_cnt = 0;
   logic done_prev = 1'b0;
   logic [ID_W-1:0]   last_id;
   logic [DATA_W-1:0] last_q;
   logic [DATA_W-1:0] last_r;
   logic              last_dz;

   always #5 clk = ~clk;

   div_sched #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_quotient  (rsp_quotient),
      .rsp_remainder (rsp_remainder),
      .rsp_dz        (rsp_dz),
      .div_start     (div_start),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_done      (div_done),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .busy          (busy)
   );

   // Reference signed divide; a zero divisor yields {-1, dividend}
   function automatic logic [31:0] model_div(input logic signed [15:0] a,
                                             input logic signed [15:0] b);
      logic signed [15:0] q;
      logic signed [15:0] r;
      if (b == 0) begin
         q = -16'sd1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural divider core with a fixed start-to-done latency
   logic [5:0]  core_cnt;
   logic        model_done;
   logic        stray_done;
   logic [15:0] core_a;
   logic [15:0] core_b;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         core_cnt   <= '0;
         model_done <= 1'b0;
         core_a     <= '0;
         core_b     <= '0;
      end else begin
         model_done <= 1'b0;
         if (div_start) begin
            core_cnt <= 6'(LAT);
            core_a   <= div_dividend;
            core_b   <= div_divisor;
         end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 6'd1;
            if (core_cnt == 6'd1) model_done <= 1'b1;
         end
      end
   end
   assign div_done = model_done | stray_done;
   assign {div_quotient, div_remainder} = model_div(core_a, core_b);

   // Monitor: push expectations on grants, compare on response handshakes
   always @(negedge clk) begin
      hs_mask = req_valid & req_ready;
      if (!reset) begin
         for (int i = 0; i < NREQ; i++) begin
            if (hs_mask[i]) begin
               exp_t e;
               logic [15:0] a;
               logic [15:0] b;
               a = req_dividend[i*DATA_W +: DATA_W];
               b = req_divisor[i*DATA_W +: DATA_W];
               e.id = ID_W'(i);
               {e.q, e.r} = model_div(a, b);
               e.dz = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
               if (b == 16'd0) e.dz = 1'b1;
`endif
               sb.push_back(e);
               grant_log.push_back(i);
            end
         end
         if (div_start) start_cnt++;
         if (done_prev) check("rsp_after_done", 32'(rsp_valid), 32'd1);
         if (model_done) check("rsp_not_early", 32'(rsp_valid), 32'd0);
         done_prev = model_done;
         if (rsp_valid && rsp_ready) begin
            last_id = rsp_id;
            last_q  = rsp_quotient;
            last_r  = rsp_remainder;
            last_dz = rsp_dz;
            if (sb.size() == 0) begin
               check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rsp_id", 32'(rsp_id), 32'(e.id));
               check("rsp_q",  32'(rsp_quotient), 32'(e.q));
               check("rsp_r",  32'(rsp_remainder), 32'(e.r));
               check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
            end
         end
      end else begin
         done_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      req_valid = req_valid & ~hs_mask;
   endtask

   task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b);
      req_dividend[id*DATA_W +: DATA_W] = a;
      req_divisor[id*DATA_W +: DATA_W]  = b;
      req_valid[id] = 1'b1;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (!(req_valid == '0 && sb.size() == 0 && !busy) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
      grant_log.delete();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int s0;
      int n;
      reset        = 1'b1;
      req_valid    = '0;
      req_dividend = '0;
      req_divisor  = '0;
      rsp_ready    = 1'b1;
      stray_done   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_div_start", 32'(div_start), 32'd0);
      check("rst_busy",      32'(busy), 32'd0);
      check("rst_rsp_q",     32'(rsp_quotient), 32'd0);
      check("rst_div_dvd",   32'(div_dividend), 32'd0);
      reset = 1'b0;
      tick();

      // Single request: 100 / 7
      s0 = start_cnt;
      issue(0, 16'd100, 16'd7);
      drain(100);
      check("t1_starts", 32'(start_cnt - s0), 32'd1);
      check("t1_id", 32'(last_id), 32'd0);
      check("t1_q", 32'(last_q), 32'd14);
      check("t1_r", 32'(last_r), 32'd2);

      // Pointer is now 1: requesters 0 and 2 together must be served 2 then 0
      grant_log.delete();
      issue(0, 16'd40, 16'd3);
      issue(2, 16'd41, 16'd5);
      drain(200);
      check("t1b_n", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         check("t1b_g0", 32'(grant_log[0]), 32'd2);
         check("t1b_g1", 32'(grant_log[1]), 32'd0);
      end

      // All four requesters from reset: grants 0,1,2,3 then wrap to 0
      do_reset();
      issue(0, 16'd1000, 16'd10);
      issue(1, -16'sd500, 16'd7);
      issue(2, 16'd77, -16'sd5);
      issue(3, -16'sd32767, 16'd3);
      drain(400);
      check("t2_n", 32'(grant_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < grant_log.size(); i++)
         check("t2_order", 32'(grant_log[i]), 32'(i));
      grant_log.delete();
      issue(3, 16'd9, 16'd4);
      issue(0, 16'd8, 16'd3);
      drain(200);
      check("t2_wrap_n", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         check("t2_wrap_g0", 32'(grant_log[0]), 32'd0);
         check("t2_wrap_g1", 32'(grant_log[1]), 32'd3);
      end

      // Negative dividend: -7 / 2
      issue(2, -16'sd7, 16'd2);
      drain(100);
      check("t3_id", 32'(last_id), 32'd2);
      check("t3_q", 32'(last_q), 32'h0000FFFD);
      check("t3_r", 32'(last_r), 32'h0000FFFF);

      // Back-pressure: response must hold for 10 cycles with no new grant
      rsp_ready = 1'b0;
      issue(1, 16'd50, 16'd6);
      n = 0;
      while (!rsp_valid && n < 100) begin
         tick();
         n++;
      end
      check("t4_wait", 32'(rsp_valid), 32'd1);
      issue(3, 16'd20, 16'd3);
      s0 = start_cnt;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("t4_valid", 32'(rsp_valid), 32'd1);
         check("t4_id", 32'(rsp_id), 32'd1);
         check("t4_q", 32'(rsp_quotient), 32'd8);
         check("t4_r", 32'(rsp_remainder), 32'd2);
         check("t4_ready", 32'(req_ready), 32'd0);
         check("t4_start", 32'(start_cnt), 32'(s0));
      end
      rsp_ready = 1'b1;
      drain(200);

      // Reset while the core is working
      s0 = start_cnt;
      issue(0, 16'd1234, 16'd10);
      n = 0;
      while (start_cnt == s0 && n < 20) begin
         tick();
         n++;
      end
      for (int k = 0; k < 5; k++) tick();
      #2;
      reset = 1'b1;
      #1;
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_div_dvd", 32'(div_dividend), 32'd0);
      check("t5_div_dvs", 32'(div_divisor), 32'd0);
      check("t5_req_ready", 32'(req_ready), 32'd0);
      check("t5_rsp_q", 32'(rsp_quotient), 32'd0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      tick();
      stray_done = 1'b1;
      tick();
      stray_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t5_no_rsp", 32'(rsp_valid), 32'd0);
      end
      issue(3, 16'd300, -16'sd7);
      drain(100);
      check("t5_id", 32'(last_id), 32'd3);
      check("t5_q", 32'(last_q), 32'h0000FFD6);
      check("t5_r", 32'(last_r), 32'd6);

      // Zero divisor
      s0 = start_cnt;
      issue(1, 16'd5, 16'd0);
      drain(100);
      check("t6_id", 32'(last_id), 32'd1);
      check("t6_q", 32'(last_q), 32'h0000FFFF);
      check("t6_r", 32'(last_r), 32'd5);
`ifdef DIV_ZERO_CHECK_EN
      check("t6_starts", 32'(start_cnt - s0), 32'd0);
      check("t6_dz", 32'(last_dz), 32'd1);
`else
      check("t6_starts", 32'(start_cnt - s0), 32'd1);
      check("t6_dz", 32'(last_dz), 32'd0);
`endif

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
